// File: rtl/tmds_channel_encoder.sv
// TMDS channel encoder: 8b/10b transition-minimised, DC-balanced symbols.
// One symbol per pixel clock, optional input register stage.
module tmds_channel_encoder #(
    parameter int REGISTER_INPUT = 1
) (
    input  logic       i_pixel_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic       i_de,
    output logic [9:0] o_tmds
);

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    // Stage A inputs (registered or straight from the ports)
    logic [7:0]        w_data;
    logic [1:0]        w_ctrl;
    logic              w_de;

    // Stage A results
    logic [8:0]        w_qm;

    // Stage B working signals
    logic [3:0]        w_n1q;
    logic signed [5:0] w_diff;
    logic signed [5:0] w_cnt_ext;
    logic signed [5:0] w_cnt_next;
    logic [9:0]        w_token;
    logic [9:0]        w_sym;
    logic              w_cnt_zero;
    logic              w_cnt_pos;
    logic              w_cnt_neg;
    logic              w_bal;
    logic              w_more1;
    logic              w_more0;

    // Stage B state
    logic signed [4:0] r_cnt;
    logic [9:0]        r_tmds;

    function automatic logic [3:0] f_pop8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] f_qm(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = f_pop8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    generate
        if (REGISTER_INPUT != 0) begin : g_in_reg
            logic [7:0] r_data;
            logic [1:0] r_ctrl;
            logic       r_de;

            // Input capture stage; reset leaves de low so a token follows
            always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_data <= 8'd0;
                    r_ctrl <= 2'd0;
                    r_de   <= 1'b0;
                end else begin
                    r_data <= i_data;
                    r_ctrl <= i_ctrl;
                    r_de   <= i_de;
                end
            end

            assign w_data = r_data;
            assign w_ctrl = r_ctrl;
            assign w_de   = r_de;
        end else begin : g_no_in_reg
            assign w_data = i_data;
            assign w_ctrl = i_ctrl;
            assign w_de   = i_de;
        end
    endgenerate

    // Stage A: transition-minimised word
    always_comb begin
        w_qm = f_qm(w_data);
    end

    // Control token lookup for blanking periods
    always_comb begin
        w_token = TOK_C00;
        unique case (w_ctrl)
            2'b00:   w_token = TOK_C00;
            2'b01:   w_token = TOK_C01;
            2'b10:   w_token = TOK_C10;
            default: w_token = TOK_C11;
        endcase
    end

    // Disparity classification of q_m[7:0] and the running count
    always_comb begin
        w_n1q      = f_pop8(w_qm[7:0]);
        w_diff     = $signed({1'b0, w_n1q, 1'b0}) - 6'sd8;
        w_cnt_ext  = {r_cnt[4], r_cnt};
        w_cnt_zero = (r_cnt == 5'sd0);
        w_cnt_neg  = r_cnt[4];
        w_cnt_pos  = !r_cnt[4] && !w_cnt_zero;
        w_bal      = (w_n1q == 4'd4);
        w_more1    = (w_n1q > 4'd4);
        w_more0    = (w_n1q < 4'd4);
    end

    // Stage B: choose symbol polarity and next running disparity
    always_comb begin
        w_sym      = w_token;
        w_cnt_next = 6'sd0;
        if (!w_de) begin
            w_sym      = w_token;
            w_cnt_next = 6'sd0;
        end else if (w_cnt_zero || w_bal) begin
            w_sym[9]   = ~w_qm[8];
            w_sym[8]   = w_qm[8];
            w_sym[7:0] = w_qm[8] ? w_qm[7:0] : ~w_qm[7:0];
            w_cnt_next = w_qm[8] ? (w_cnt_ext + w_diff)
                                 : (w_cnt_ext - w_diff);
        end else if ((w_cnt_pos && w_more1) ||
                     (w_cnt_neg && w_more0)) begin
            w_sym      = {1'b1, w_qm[8], ~w_qm[7:0]};
            w_cnt_next = w_cnt_ext - w_diff
                       + (w_qm[8] ? 6'sd2 : 6'sd0);
        end else begin
            w_sym      = {1'b0, w_qm[8], w_qm[7:0]};
            w_cnt_next = w_cnt_ext + w_diff
                       - (w_qm[8] ? 6'sd0 : 6'sd2);
        end
    end

    // Output symbol and disparity registers
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tmds <= TOK_C00;
            r_cnt  <= 5'sd0;
        end else begin
            r_tmds <= w_sym;
            r_cnt  <= 5'(w_cnt_next);
        end
    end

    assign o_tmds = r_tmds;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: both latency variants side by side,
// compared every cycle against a behavioural TMDS model.
`timescale 1ns/1ps
module tb_tmds_channel_encoder;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [7:0] i_data = 8'd0;
    logic [1:0] i_ctrl = 2'd0;
    logic       i_de = 1'b0;
    logic [9:0] o_tmds_r1;
    logic [9:0] o_tmds_r0;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] TOK00 = 10'h354;
    logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    always #5 clk = ~clk;

    tmds_channel_encoder #(.REGISTER_INPUT(1)) u_dut1 (
        .i_pixel_clk(clk),
        .i_reset_n  (i_reset_n),
        .i_data     (i_data),
        .i_ctrl     (i_ctrl),
        .i_de       (i_de),
        .o_tmds     (o_tmds_r1)
    );

    tmds_channel_encoder #(.REGISTER_INPUT(0)) u_dut0 (
        .i_pixel_clk(clk),
        .i_reset_n  (i_reset_n),
        .i_data     (i_data),
        .i_ctrl     (i_ctrl),
        .i_de       (i_de),
        .o_tmds     (o_tmds_r0)
    );

    task automatic check(input string nm, input logic [9:0] act,
                         input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt = 0;
    logic [9:0] exp0 = TOK00;
    logic [9:0] exp1 = TOK00;
    logic [9:0] m_prev = TOK00;
    logic       exp0_de = 1'b0;
    logic [7:0] exp0_data = 8'd0;

    task automatic ref_encode(input logic de, input logic [1:0] c,
                              input logic [7:0] d,
                              output logic [9:0] sym);
        int n1d, n1q, n0q;
        logic xm, par;
        logic [8:0] q;
        if (!de) begin
            m_cnt = 0;
            sym = tok[c];
            return;
        end
        n1d = $countones(d);
        xm = (n1d > 4) || (n1d == 4 && !d[0]);
        // XOR chain is a prefix parity; XNOR flips every odd position
        par = 1'b0;
        for (int i = 0; i < 8; i++) begin
            par = par ^ d[i];
            q[i] = par ^ (xm && (i % 2 == 1));
        end
        q[8] = !xm;
        n1q = $countones(q[7:0]);
        n0q = 8 - n1q;
        if (m_cnt == 0 || n1q == n0q) begin
            sym = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
            m_cnt += q[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((m_cnt > 0 && n1q > n0q) ||
                     (m_cnt < 0 && n0q > n1q)) begin
            sym = {1'b1, q[8], ~q[7:0]};
            m_cnt += (q[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            sym = {1'b0, q[8], q[7:0]};
            m_cnt += (n1q - n0q) - (q[8] ? 0 : 2);
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] d, r;
        d = s[9] ? ~s[7:0] : s[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++)
            r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return r;
    endfunction

    always @(posedge clk or negedge i_reset_n) begin
        logic [9:0] sym;
        if (!i_reset_n) begin
            m_cnt = 0;
            exp0 = TOK00;
            exp1 = TOK00;
            m_prev = TOK00;
            exp0_de = 1'b0;
        end else begin
            ref_encode(i_de, i_ctrl, i_data, sym);
            exp1 = m_prev;
            exp0 = sym;
            m_prev = sym;
            exp0_de = i_de;
            exp0_data = i_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    int disp = 0;
    always @(negedge clk) begin
        check("stream_r0", o_tmds_r0, exp0);
        check("stream_r1", o_tmds_r1, exp1);
        if (!i_reset_n || !exp0_de) begin
            disp = 0;
        end else begin
            disp += 2 * $countones(o_tmds_r0) - 10;
            checks++;
            if (disp > 10 || disp < -10) begin
                errors++;
                if (errors <= 40)
                    $display("FAIL disparity: got %0d expected within +-10",
                             disp);
            end
            check("decode", {2'b00, decode(o_tmds_r0)},
                  {2'b00, exp0_data});
        end
    end

    // ---------------- directed helpers ----------------
    logic [9:0] lit_prev = TOK00;

    task automatic step(input logic de, input logic [1:0] c,
                        input logic [7:0] d, input logic [9:0] lit,
                        input string nm);
        @(negedge clk);
        i_de = de;
        i_ctrl = c;
        i_data = d;
        @(posedge clk);
        #1;
        check({nm, "_r0"}, o_tmds_r0, lit);
        check({nm, "_model"}, exp0, lit);
        check({nm, "_r1"}, o_tmds_r1, lit_prev);
        lit_prev = lit;
    endtask

    task automatic drive(input logic de, input logic [1:0] c,
                         input logic [7:0] d);
        @(negedge clk);
        i_de = de;
        i_ctrl = c;
        i_data = d;
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #($urandom_range(1, 3));
        i_reset_n = 1'b0;
        #1;
        check("rst_async_r0", o_tmds_r0, TOK00);
        check("rst_async_r1", o_tmds_r1, TOK00);
        @(negedge clk);
        i_de = 1'b1;
        i_ctrl = 2'd0;
        i_data = 8'h00;
        repeat (2) @(posedge clk);
        #($urandom_range(6, 9));
        i_reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_r0", o_tmds_r0, 10'h100);
        check("post_rst_r1", o_tmds_r1, TOK00);
        @(posedge clk);
        #1;
        check("post_rst_r1_data", o_tmds_r1, 10'h100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs: token 00 throughout
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 2'($urandom), 8'($urandom));
            @(posedge clk);
            #1;
            check("rst_hold_r0", o_tmds_r0, TOK00);
            check("rst_hold_r1", o_tmds_r1, TOK00);
        end
        @(negedge clk);
        i_de = 1'b0;
        i_ctrl = 2'd0;
        #2;
        i_reset_n = 1'b1;

        step(1'b0, 2'd0, 8'h00, 10'h354, "blank");
        step(1'b0, 2'd0, 8'h00, 10'h354, "blank");

        // Control tokens in order
        step(1'b0, 2'd0, 8'h00, 10'h354, "ctrl00");
        step(1'b0, 2'd1, 8'h00, 10'h0AB, "ctrl01");
        step(1'b0, 2'd2, 8'h00, 10'h154, "ctrl10");
        step(1'b0, 2'd3, 8'h00, 10'h2AB, "ctrl11");
        step(1'b0, 2'd0, 8'h00, 10'h354, "blank");

        // Two zero bytes: balanced start, then inverted recovery
        step(1'b1, 2'd0, 8'h00, 10'h100, "zero_a");
        step(1'b1, 2'd0, 8'h00, 10'h3FF, "zero_b");
        step(1'b0, 2'd0, 8'h00, 10'h354, "blank");

        // All-ones byte after blanking
        step(1'b1, 2'd0, 8'hFF, 10'h200, "ones");
        step(1'b0, 2'd2, 8'h00, 10'h154, "blank10");
        step(1'b0, 2'd0, 8'h00, 10'h354, "blank");

        // Long active run of random bytes
        for (int i = 0; i < 10000; i++) begin
            drive(1'b1, 2'd0, 8'($urandom));
            if (i == 4000) mid_reset();
        end

        // Mixed blanking and active traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 7) != 0), 2'($urandom),
                  8'($urandom));
            if (i == 700) mid_reset();
        end

        drive(1'b0, 2'd0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_channel_encoder.md
TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

Interface
REQ-001 SHALL have parameter REGISTER_INPUT, default 1: 1 = input register stage present (latency 2), 0 = no input register (latency 1).
REQ-002 SHALL have port i_pixel_clk, input, 1 bit: pixel clock; the only clock.
REQ-003 SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port i_data, input, 8 bits: pixel component for this channel.
REQ-005 SHALL have port i_ctrl, input, 2 bits: control pair; {vsync, hsync} on channel 0, else 0.
REQ-006 SHALL have port i_de, input, 1 bit: display enable; 1 = encode i_data, 0 = send control token.
REQ-007 SHALL have port o_tmds, output, 10 bits: TMDS symbol, bit 0 transmitted first.

Function
REQ-008 SHALL sample i_data, i_ctrl and i_de on the rising edge of i_pixel_clk.
- o_tmds reflects the inputs of cycle N at cycle N+2 (REGISTER_INPUT=1) or N+1 (REGISTER_INPUT=0).
- Throughput: one symbol per clock; no stalls.
REQ-009 Stage A SHALL compute the transition-minimised word q_m[8:0].
- N1d = popcount(data).
- XNOR mode when N1d>4, or N1d==4 and data[0]==0; otherwise XOR mode.
- q_m[0] = data[0]; q_m[i] = q_m[i-1] XNOR/XOR data[i], i = 1..7.
- q_m[8] = 0 in XNOR mode, 1 in XOR mode.
REQ-010 Stage B SHALL hold a running disparity counter cnt.
- cnt is 5-bit signed; N1q and N0q are the ones/zeros counts of q_m[7:0].
REQ-011 With de=1 and (cnt==0 or N1q==N0q), stage B SHALL apply this rule.
- o[9] = ~q_m[8]; o[8] = q_m[8].
- o[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
- cnt += q_m[8] ? (N1q-N0q) : (N0q-N1q).
REQ-012 Otherwise, with de=1 and ((cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q)), stage B SHALL invert.
- o[9] = 1; o[8] = q_m[8]; o[7:0] = ~q_m[7:0].
- cnt += 2*q_m[8] + (N0q-N1q).
REQ-013 In every other de=1 case, stage B SHALL pass through.
- o[9] = 0; o[8] = q_m[8]; o[7:0] = q_m[7:0].
- cnt += (N1q-N0q) - 2*(~q_m[8]).
REQ-014 With de=0, stage B SHALL output a control token and force cnt to 0.
- ctrl 00 -> 10'b1101010100; 01 -> 10'b0010101011.
- ctrl 10 -> 10'b0101010100; 11 -> 10'b1010101011.
REQ-015 de and ctrl SHALL be pipelined alongside data so that the token/data choice is aligned with the same-cycle input.
REQ-016 cnt SHALL stay within -10..+10; arithmetic is sign-extended, no truncation.
REQ-017 A de 0->1 transition SHALL start encoding with cnt=0; a 1->0 transition SHALL emit a token on the first blanking symbol.

Reset
REQ-018 While i_reset_n=0, the block SHALL asynchronously clear all pipeline registers.
- o_tmds = 10'b1101010100; cnt = 0; internal de = 0.
REQ-019 On reset release, the block SHALL resume on the next rising edge with no extra latency.
- Reset asserted mid-line discards all in-flight symbols.

Verification
REQ-020 Bench SHALL cover: reset held, random inputs -> o_tmds constant 10'b1101010100.
REQ-021 Bench SHALL cover: de=0, ctrl 00/01/10/11 on consecutive cycles -> 0x354, 0x0AB, 0x154, 0x2AB after latency, in order.
REQ-022 Bench SHALL cover: de=1 after blanking, data 0x00 then 0x00 -> 0x100 (cnt -8), then 0x3FF (cnt +2).
REQ-023 Bench SHALL cover: de=1 after blanking, data 0xFF -> 0x200 (cnt -8).
REQ-024 Bench SHALL cover: 10k random de=1 bytes against a reference model.
- Expect bit-exact match.
- cnt within ±10.
- Decoding each symbol recovers the data byte.
REQ-025 Bench SHALL cover: i_reset_n pulsed low mid-stream, asynchronous to the clock.
- o_tmds = 0x354 immediately.
- First post-reset data symbol is encoded with cnt=0.
- Run with both REGISTER_INPUT values.
